// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-driven ALU engine.
package uart_alu_pkg;

    localparam logic [7:0]  ERR_BYTE  = 8'hEE;
    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [7:0] {
        OP_ADD = 8'h10,
        OP_MUL = 8'h11,
        OP_XOR = 8'h12,
        OP_MAX = 8'h13
    } opcode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RSV,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_OPND,
        ST_EXEC,
        ST_RESP,
        ST_DRAIN,
        ST_ERR_RESP
    } state_e;

    function automatic logic opcode_valid(input logic [7:0] op);
        return op inside {OP_ADD, OP_MUL, OP_XOR, OP_MAX};
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, mul_iter_p multiplier bits per cycle.
// done is raised in the cycle that produces the final (truncated) product.
module shift_add_mul #(
    parameter int unsigned width_p    = 32,
    parameter int unsigned mul_iter_p = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width_p-1:0] a,
    input  logic [width_p-1:0] b,
    output logic               done,
    output logic [width_p-1:0] product
);
    localparam int unsigned   STEPS     = width_p / mul_iter_p;
    localparam int unsigned   CW        = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    logic               running;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cur;
    logic [width_p-1:0] mcand;
    logic [width_p-1:0] mplier;
    logic [width_p-1:0] partial;
    logic [width_p-1:0] src_a;
    logic [width_p-1:0] src_b;
    logic [width_p-1:0] sum;

    // The start cycle already performs the first step on the live operands.
    always_comb begin
        src_a = start ? a : mcand;
        src_b = start ? b : mplier;
        sum   = start ? '0 : partial;
        for (int j = 0; j < int'(mul_iter_p); j++) begin
            if (src_b[j]) begin
                sum = sum + (src_a << j);
            end
        end
    end

    assign cur     = start ? '0 : cnt;
    assign done    = (start | running) & (cur == LAST_STEP);
    assign product = sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
        end else if (start | running) begin
            mcand   <= src_a << mul_iter_p;
            mplier  <= src_b >> mul_iter_p;
            partial <= sum;
            running <= ~done;
            cnt     <= done ? '0 : cur + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_engine.sv
// Byte-stream packet ALU: parses opcode/length header, folds operands into an
// accumulator and streams the result (or an error byte) back out.
module uart_alu_engine
    import uart_alu_pkg::*;
#(
    parameter int unsigned width_p    = 32,
    parameter int unsigned mul_iter_p = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);
    localparam int unsigned    NBYTES   = width_p / 8;
    localparam int unsigned    BCW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [15:0]    HDR_LEN  = 16'(HDR_BYTES);
    localparam logic [15:0]    MIN_LEN  = 16'(HDR_BYTES + NBYTES);
    localparam logic [15:0]    OPND_LEN = 16'(NBYTES);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(NBYTES - 1);

    state_e             state;
    state_e             state_next;
    logic [7:0]         op;
    logic [7:0]         len_lo;
    logic [15:0]        rem;
    logic [BCW-1:0]     byte_cnt;
    logic [width_p-1:0] acc;
    logic [width_p-1:0] opnd;
    logic [width_p-1:0] alu_result;
    logic [width_p-1:0] mul_prod;
    logic               first;
    logic               exec_entry;
    logic               err;
    logic               rx_fire;
    logic               tx_fire;
    logic               last_byte;
    logic [15:0]        len_full;
    logic [15:0]        drain_len;
    logic               len_ok;
    logic               pkt_ok;
    logic               is_mul;
    logic               exec_done;
    logic               mul_start;
    logic               mul_done;

    // Reset gates the handshakes so nothing transfers while rst_i is high.
    assign rx_ready_o = ~rst_i & ((state inside {ST_IDLE, ST_RSV, ST_LEN_LO, ST_LEN_HI, ST_OPND})
                                  | ((state == ST_DRAIN) & (rem != '0)));
    assign tx_valid_o = ~rst_i & ((state == ST_RESP) | (state == ST_ERR_RESP));
    assign tx_data_o  = acc[7:0];
    assign busy_o     = ~rst_i & (state != ST_IDLE);
    assign err_o      = ~rst_i & err;

    assign rx_fire   = rx_valid_i & rx_ready_o;
    assign tx_fire   = tx_valid_o & tx_ready_i;
    assign last_byte = (byte_cnt == LAST_IDX);
    assign len_full  = {rx_data_i, len_lo};
    assign drain_len = (len_full < HDR_LEN) ? '0 : len_full - HDR_LEN;
    assign len_ok    = (len_full >= MIN_LEN) && ((drain_len % OPND_LEN) == '0);
    assign pkt_ok    = opcode_valid(op) && len_ok;
    assign is_mul    = (op == OP_MUL);
    assign exec_done = first | ~is_mul | mul_done;
    assign mul_start = (state == ST_EXEC) & exec_entry & ~first & is_mul;

    shift_add_mul #(
        .width_p    (width_p),
        .mul_iter_p (mul_iter_p)
    ) u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (mul_start),
        .a       (acc),
        .b       (opnd),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        alu_result = acc;
        if (first) begin
            alu_result = opnd;
        end else begin
            case (op)
                OP_ADD:  alu_result = acc + opnd;
                OP_MUL:  alu_result = mul_prod;
                OP_XOR:  alu_result = acc ^ opnd;
                OP_MAX:  alu_result = (opnd > acc) ? opnd : acc;
                default: alu_result = acc;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (rx_fire) state_next = ST_RSV;
            ST_RSV:      if (rx_fire) state_next = ST_LEN_LO;
            ST_LEN_LO:   if (rx_fire) state_next = ST_LEN_HI;
            ST_LEN_HI:   if (rx_fire) state_next = pkt_ok ? ST_OPND : ST_DRAIN;
            ST_OPND:     if (rx_fire && last_byte) state_next = ST_EXEC;
            ST_EXEC:     if (exec_done) state_next = (rem == '0) ? ST_RESP : ST_OPND;
            ST_RESP:     if (tx_fire && last_byte) state_next = ST_IDLE;
            ST_DRAIN:    if ((rem == '0) || (rx_fire && (rem == 16'd1))) state_next = ST_ERR_RESP;
            ST_ERR_RESP: if (tx_fire) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Datapath: rem counts operand (or drained) bytes still expected.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op         <= '0;
            len_lo     <= '0;
            rem        <= '0;
            byte_cnt   <= '0;
            acc        <= '0;
            opnd       <= '0;
            first      <= 1'b0;
            exec_entry <= 1'b0;
            err        <= 1'b0;
        end else begin
            err        <= 1'b0;
            exec_entry <= 1'b0;
            case (state)
                ST_IDLE: if (rx_fire) begin
                    op       <= rx_data_i;
                    first    <= 1'b1;
                    byte_cnt <= '0;
                end
                ST_LEN_LO: if (rx_fire) len_lo <= rx_data_i;
                ST_LEN_HI: if (rx_fire) begin
                    rem      <= drain_len;
                    err      <= ~pkt_ok;
                    byte_cnt <= '0;
                    if (!pkt_ok) acc <= width_p'(ERR_BYTE);
                end
                ST_OPND: if (rx_fire) begin
                    opnd       <= (opnd >> 8) | (width_p'(rx_data_i) << (width_p - 8));
                    rem        <= rem - 1'b1;
                    byte_cnt   <= last_byte ? '0 : byte_cnt + 1'b1;
                    exec_entry <= last_byte;
                end
                ST_EXEC: if (exec_done) begin
                    acc   <= alu_result;
                    first <= 1'b0;
                end
                ST_RESP: if (tx_fire) begin
                    acc      <= acc >> 8;
                    byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                end
                ST_DRAIN: if (rx_fire) rem <= rem - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed + randomized packet bench for uart_alu_engine with a packet-level
// arithmetic reference model.
module tb_uart_alu_engine;
    typedef logic [7:0]  byteq_t[$];
    typedef logic [31:0] wordq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;

    int total    = 0;
    int bad      = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    uart_alu_engine #(.width_p(32), .mul_iter_p(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .err_o      (err)
    );

    always @(negedge clk) if (err) err_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: fold operands with the opcode's arithmetic.
    function automatic logic [31:0] model(input logic [7:0] op, input wordq_t v);
        logic [31:0] r;
        if (op < 8'h10 || op > 8'h13) return 32'h0000_00EE;
        r = v[0];
        for (int i = 1; i < v.size(); i++) begin
            case (op)
                8'h10:   r = r + v[i];
                8'h11:   r = r * v[i];
                8'h12:   r = r ^ v[i];
                default: r = (v[i] > r) ? v[i] : r;
            endcase
        end
        return r;
    endfunction

    task automatic build_pkt(input logic [7:0] op, input wordq_t v, output byteq_t p);
        int len;
        len = 4 + 4 * v.size();
        p = {};
        p.push_back(op);
        p.push_back(8'($urandom));
        p.push_back(8'(len));
        p.push_back(8'(len >> 8));
        foreach (v[i]) for (int k = 0; k < 4; k++) p.push_back(8'(v[i] >> (8 * k)));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("rx_accept_wait", 32'(t < 300), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input byteq_t p, input int maxgap);
        foreach (p[i]) send_byte(p[i], $urandom_range(0, maxgap));
    endtask

    task automatic get_resp(input int n, input int stall, output logic [31:0] val);
        logic [7:0] b;
        int t;
        val = '0;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!tx_valid && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check("tx_valid_wait", 32'(t < 2000), 32'd1);
            if (t >= 2000) return;
            b = tx_data;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(b));
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            val[8*i +: 8] = b;
        end
    endtask

    task automatic reset_and_quiet(input string tag);
        int tx_seen;
        rst = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_rst_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_rst_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_err"}, 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        check({tag, "_rx_ready_after_rst"}, 32'(rx_ready), 32'd1);
        tx_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid) tx_seen++;
        end
        tx_ready = 1'b0;
        check({tag, "_no_tx_after_rst"}, 32'(tx_seen), 32'd0);
    endtask

    initial begin
        byteq_t      p;
        wordq_t      v;
        logic [31:0] got;
        int          eb;
        int          cyc;
        bit          all_low;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("init_rx_ready", 32'(rx_ready), 32'd0);
        check("init_tx_valid", 32'(tx_valid), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        check("rx_ready_first_cycle", 32'(rx_ready), 32'd1);
        @(negedge clk);

        // ADD 1 + 2
        p = {8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(p, 0);
        get_resp(4, 0, got);
        check("add_result", got, 32'h0000_0003);
        check("add_idle", 32'(busy), 32'd0);

        // MUL overflow with exec-length measurement
        p = {8'h11, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        send_pkt(p, 0);
        cyc = 0;
        all_low = 1'b1;
        while (!tx_valid && cyc < 1000) begin
            if (rx_ready) all_low = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check("mul_exec_cycles", 32'(cyc), 32'd32);
        check("mul_rx_ready_low", 32'(all_low), 32'd1);
        get_resp(4, 0, got);
        check("mul_result", got, 32'h0000_0000);

        // MAX of three
        build_pkt(8'h13, {32'd5, 32'hFFFF_FFFF, 32'd7}, p);
        send_pkt(p, 1);
        get_resp(4, 0, got);
        check("max_result", got, 32'hFFFF_FFFF);

        // bad opcode, then a good ADD
        eb = err_seen;
        p = {8'h55, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_pkt(p, 0);
        get_resp(1, 0, got);
        check("badop_resp", got, 32'h0000_00EE);
        check("badop_err_pulses", 32'(err_seen - eb), 32'd1);
        v = {32'h1234_5678, 32'h0FED_CBA9};
        build_pkt(8'h10, v, p);
        send_pkt(p, 0);
        get_resp(4, 0, got);
        check("add_after_badop", got, model(8'h10, v));

        // bad length, then a stalled response
        eb = err_seen;
        p = {8'h10, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(p, 0);
        get_resp(1, 0, got);
        check("badlen_resp", got, 32'h0000_00EE);
        check("badlen_err_pulses", 32'(err_seen - eb), 32'd1);
        v = {32'hA5A5_0F0F, 32'h1111_2222};
        build_pkt(8'h12, v, p);
        send_pkt(p, 0);
        get_resp(4, 10, got);
        check("stalled_xor", got, model(8'h12, v));

        // reset mid-packet
        p = {8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
        send_pkt(p, 0);
        reset_and_quiet("midpkt");
        v = {32'd40, 32'd2};
        build_pkt(8'h10, v, p);
        send_pkt(p, 0);
        get_resp(4, 0, got);
        check("after_midpkt_rst", got, 32'd42);

        // reset mid-response
        build_pkt(8'h10, {32'h0102_0304, 32'd0}, p);
        send_pkt(p, 0);
        get_resp(1, 0, got);
        reset_and_quiet("midresp");
        v = {32'd9, 32'd6};
        build_pkt(8'h13, v, p);
        send_pkt(p, 0);
        get_resp(4, 0, got);
        check("after_midresp_rst", got, 32'd9);

        // randomized packets
        for (int it = 0; it < 40; it++) begin
            logic [7:0] op;
            bit         isbad;
            int         k;
            isbad = ($urandom_range(0, 7) == 0);
            op = isbad ? 8'(32'h20 + $urandom_range(0, 32'hDF)) : 8'(32'h10 + $urandom_range(0, 3));
            k = $urandom_range(1, 4);
            v = {};
            for (int j = 0; j < k; j++) begin
                case ($urandom_range(0, 5))
                    0:       v.push_back(32'd0);
                    1:       v.push_back(32'hFFFF_FFFF);
                    default: v.push_back($urandom);
                endcase
            end
            eb = err_seen;
            build_pkt(op, v, p);
            send_pkt(p, 2);
            get_resp(isbad ? 1 : 4, $urandom_range(0, 3), got);
            check("rand_result", got, model(op, v));
            check("rand_err", 32'(err_seen - eb), isbad ? 32'd1 : 32'd0);
        end

        check("final_idle", 32'(busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_engine.md
UART_ALU_ENGINE -- requirements
Module: uart_alu_engine

Interface
REQ-001 Parameter width_p, default 32, operand/result width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter mul_iter_p, default 1, result bits processed per multiply iteration; SHALL divide width_p.
REQ-003 clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 rx_data_i  in  8  received byte from UART receiver.
REQ-006 rx_valid_i  in  1  rx_data_i valid.
REQ-007 rx_ready_o  out  1  engine accepts byte; transfer occurs when rx_valid_i and rx_ready_o are both high.
REQ-008 tx_data_o  out  8  byte to UART transmitter.
REQ-009 tx_valid_o  out  1  tx_data_o valid.
REQ-010 tx_ready_i  in  1  transmitter accepts byte.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 err_o  out  1  one-cycle pulse when a packet is rejected.

Function
REQ-013 Packet format: byte0 opcode, byte1 reserved (ignored), bytes2-3 total length L in bytes (little-endian, header included), then K operands of B=width_p/8 bytes each, little-endian.
REQ-014 Opcodes: 0x10 ADD, 0x11 MUL, 0x12 XOR, 0x13 MAX (unsigned); all results truncated to width_p bits, wrap-around on overflow.
REQ-015 States: IDLE -> RSV -> LEN_LO -> LEN_HI -> OPND <-> EXEC -> RESP -> IDLE; error path LEN_HI -> DRAIN -> ERR_RESP -> IDLE.
REQ-016 Each state from IDLE to LEN_HI advances on exactly one accepted byte.
REQ-017 L is valid iff L >= 4+B and (L-4) mod B == 0; opcode is valid iff listed in REQ-014.
REQ-018 On invalid opcode or invalid L: err_o pulses in the cycle after LEN_HI accepts its byte; DRAIN then discards exactly L-4 bytes (0 if L<4) before entering ERR_RESP.
REQ-019 rx_ready_o high in IDLE, RSV, LEN_LO, LEN_HI, OPND, DRAIN; low in EXEC, RESP, ERR_RESP.
REQ-020 OPND assembles B bytes (first byte = LSB), then enters EXEC.
REQ-021 The first operand of a packet loads the accumulator directly (1 EXEC cycle, any opcode).
REQ-022 For subsequent operands, EXEC SHALL take 1 cycle for ADD/XOR/MAX and width_p/mul_iter_p cycles for MUL (shift-add).
REQ-023 After EXEC, return to OPND if operands remain, else go to RESP.
REQ-024 RESP presents the accumulator as B bytes, LSB first; tx_valid_o stays high with stable tx_data_o until tx_ready_i; IDLE follows the cycle after the last byte is accepted.
REQ-025 ERR_RESP sends a single byte 0xEE under the same handshake, then returns to IDLE.
REQ-026 A new packet byte presented during RESP/ERR_RESP SHALL be stalled, never dropped.

Reset
REQ-027 While rst_i is high: state=IDLE, accumulator=0, byte/operand counters=0, and rx_ready_o, tx_valid_o, busy_o, err_o all 0.
REQ-028 rx_ready_o SHALL be 1 in the first cycle after rst_i deasserts.
REQ-029 Reset mid-packet or mid-response abandons all work; no partial byte is re-sent after reset.

Structure
REQ-030 Package uart_alu_pkg SHALL hold the opcode enum, state enum, ERR_BYTE=0xEE and HDR_BYTES=4.
REQ-031 MUL SHALL be a sub-module shift_add_mul (start/done, parametrised by width_p and mul_iter_p).

Verification (width_p=32, mul_iter_p=1)
REQ-032 ADD: 10 00 0C 00 01 00 00 00 02 00 00 00 -> tx 03 00 00 00.
REQ-033 MUL overflow: 11 00 0C 00 00 00 01 00 00 00 01 00 -> tx 00 00 00 00; rx_ready_o is low for exactly 32 cycles during the second-operand EXEC.
REQ-034 MAX of three operands: 13 00 10 00, operands 5, 0xFFFFFFFF, 7 -> tx FF FF FF FF.
REQ-035 Bad opcode: 55 00 08 00 AA BB CC DD -> err_o pulses once, 4 bytes drained, tx EE, then an ADD packet is processed correctly.
REQ-036 Bad length: 10 00 0A 00 plus 6 bytes -> err_o pulses, tx EE; tx_ready_i held low for 10 cycles during RESP of the next packet keeps tx_data_o stable.
REQ-037 rst_i asserted after the 6th byte of the REQ-032 packet -> no tx; a fresh packet yields its correct result.
